// File: rtl/jk_mon_pkg.sv
// Shared definitions for the JK flip-flop monitor: FSM state enum, J/K mode
// codes and the reference next-state function of an ideal JK flop.
package jk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } jk_state_e;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_RST  = 2'd1;
  localparam logic [1:0] MODE_SET  = 2'd2;
  localparam logic [1:0] MODE_TOG  = 2'd3;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic nq;
    case ({j, k})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      default: nq = ~q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_ff_monitor_expect.sv
// jk_expect: combinational expected-Q and mode decode from the previously
// sampled J/K/Q/dut_reset; an observed flop reset forces Q=0 and mode "reset".
module jk_expect
  import jk_mon_pkg::*;
(
  input  logic       prev_j,
  input  logic       prev_k,
  input  logic       prev_q,
  input  logic       prev_dut_reset,
  output logic       exp_q,
  output logic [1:0] mode
);

  always_comb begin
    exp_q = 1'b0;
    mode  = MODE_RST;
    if (!prev_dut_reset) begin
      exp_q = jk_next(prev_j, prev_k, prev_q);
      mode  = {prev_j, prev_k};
    end
  end

endmodule

// File: rtl/jk_ff_monitor.sv
// JK flip-flop protocol monitor. Define JK_MON_MODE_COUNTERS_EN to add the
// per-mode transition counters (cnt_hold, cnt_set, cnt_rst, cnt_tog).
module jk_ff_monitor #(
  parameter int CNT_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dut_reset,
  input  logic             J,
  input  logic             K,
  input  logic             Q,
  input  logic             Qn,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       first_err_mode,
  output logic [1:0]       state
`ifdef JK_MON_MODE_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cnt_hold,
  output logic [CNT_W-1:0] cnt_set,
  output logic [CNT_W-1:0] cnt_rst,
  output logic [CNT_W-1:0] cnt_tog
`endif
);

  import jk_mon_pkg::*;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SYNC  = SYNC;
  localparam logic [1:0] S_CHECK = CHECK;
  localparam logic [1:0] S_HALT  = HALT;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic       prev_j, prev_k, prev_q, prev_dut_reset, prev_valid;
  logic       exp_q;
  logic [1:0] mode;
  logic       checking;
  logic       fail;

  jk_expect u_expect (
    .prev_j         (prev_j),
    .prev_k         (prev_k),
    .prev_q         (prev_q),
    .prev_dut_reset (prev_dut_reset),
    .exp_q          (exp_q),
    .mode           (mode)
  );

  // A falling en wins over a mismatch: nothing is checked on that edge.
  assign checking = (state == S_CHECK) && en && prev_valid;
  assign fail     = checking && ((Q != exp_q) || (Qn == Q));

  // Observed-value stage: compare against what the flop really held last cycle.
  always_ff @(posedge clk) begin
    if (state == S_SYNC || state == S_CHECK) begin
      prev_j         <= J;
      prev_k         <= K;
      prev_q         <= Q;
      prev_dut_reset <= dut_reset;
    end
  end

  // Control and result stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      err            <= 1'b0;
      err_sticky     <= 1'b0;
      err_cnt        <= '0;
      first_err_mode <= MODE_HOLD;
      prev_valid     <= 1'b0;
`ifdef JK_MON_MODE_COUNTERS_EN
      cnt_hold <= '0;
      cnt_set  <= '0;
      cnt_rst  <= '0;
      cnt_tog  <= '0;
`endif
    end else begin
      err <= fail;
      case (state)
        S_IDLE: begin
          err_sticky <= 1'b0;
          prev_valid <= 1'b0;
          if (en) begin
            state          <= S_SYNC;
            err_cnt        <= '0;
            first_err_mode <= MODE_HOLD;
`ifdef JK_MON_MODE_COUNTERS_EN
            cnt_hold <= '0;
            cnt_set  <= '0;
            cnt_rst  <= '0;
            cnt_tog  <= '0;
`endif
          end
        end
        S_SYNC: begin
          prev_valid <= 1'b1;
          state      <= en ? S_CHECK : S_IDLE;
        end
        S_CHECK: begin
          prev_valid <= 1'b1;
          if (!en)
            state <= S_IDLE;
          else if (fail && (STOP_ON_ERR != 0))
            state <= S_HALT;
        end
        default: begin
          if (!en)
            state <= S_IDLE;
        end
      endcase
      if (fail) begin
        err_sticky <= 1'b1;
        err_cnt    <= sat_inc(err_cnt);
        if (!err_sticky)
          first_err_mode <= mode;
      end
`ifdef JK_MON_MODE_COUNTERS_EN
      if (checking) begin
        case (mode)
          MODE_HOLD: cnt_hold <= sat_inc(cnt_hold);
          MODE_RST:  cnt_rst  <= sat_inc(cnt_rst);
          MODE_SET:  cnt_set  <= sat_inc(cnt_set);
          default:   cnt_tog  <= sat_inc(cnt_tog);
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Self-checking bench for jk_ff_monitor: three instances (default, halt on
// error, 2-bit counters) share stimulus and are compared to a behavioural model.
module tb_jk_ff_monitor;

  logic clk = 1'b0;
  logic reset, en, dut_reset, j, k, q, qn;

  logic       err_a, stk_a, err_h, stk_h, err_n, stk_n;
  logic [7:0] cnt_a, cnt_h;
  logic [1:0] cnt_n;
  logic [1:0] fem_a, fem_h, fem_n, st_a, st_h, st_n;
`ifdef JK_MON_MODE_COUNTERS_EN
  logic [7:0] ch_a, cs_a, cr_a, ct_a, ch_h, cs_h, cr_h, ct_h;
  logic [1:0] ch_n, cs_n, cr_n, ct_n;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jk_ff_monitor u_a (
    .clk(clk), .reset(reset), .en(en), .dut_reset(dut_reset), .J(j), .K(k), .Q(q), .Qn(qn),
    .err(err_a), .err_sticky(stk_a), .err_cnt(cnt_a), .first_err_mode(fem_a), .state(st_a)
`ifdef JK_MON_MODE_COUNTERS_EN
    , .cnt_hold(ch_a), .cnt_set(cs_a), .cnt_rst(cr_a), .cnt_tog(ct_a)
`endif
  );

  jk_ff_monitor #(.STOP_ON_ERR(1)) u_h (
    .clk(clk), .reset(reset), .en(en), .dut_reset(dut_reset), .J(j), .K(k), .Q(q), .Qn(qn),
    .err(err_h), .err_sticky(stk_h), .err_cnt(cnt_h), .first_err_mode(fem_h), .state(st_h)
`ifdef JK_MON_MODE_COUNTERS_EN
    , .cnt_hold(ch_h), .cnt_set(cs_h), .cnt_rst(cr_h), .cnt_tog(ct_h)
`endif
  );

  jk_ff_monitor #(.CNT_W(2)) u_n (
    .clk(clk), .reset(reset), .en(en), .dut_reset(dut_reset), .J(j), .K(k), .Q(q), .Qn(qn),
    .err(err_n), .err_sticky(stk_n), .err_cnt(cnt_n), .first_err_mode(fem_n), .state(st_n)
`ifdef JK_MON_MODE_COUNTERS_EN
    , .cnt_hold(ch_n), .cnt_set(cs_n), .cnt_rst(cr_n), .cnt_tog(ct_n)
`endif
  );

  // Reference model, one slot per instance: 0 = default, 1 = halt, 2 = CNT_W=2.
  int stop_cfg[3] = '{0, 1, 0};
  int cmax[3]     = '{255, 255, 3};
  int ms[3], merr[3], mstk[3], mcnt[3], mfem[3];
  int mpj[3], mpk[3], mpq[3], mpr[3];
  int mmode[3][4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 3; m++) begin
      merr[m] = 0;
      if (!reset) begin
        ms[m] = 0; mstk[m] = 0; mcnt[m] = 0; mfem[m] = 0;
        for (int c = 0; c < 4; c++) mmode[m][c] = 0;
      end else if (ms[m] == 0) begin
        mstk[m] = 0;
        if (en) begin
          ms[m] = 1; mcnt[m] = 0; mfem[m] = 0;
          for (int c = 0; c < 4; c++) mmode[m][c] = 0;
        end
      end else if (ms[m] == 3) begin
        if (!en) ms[m] = 0;
      end else begin
        if (!en) ms[m] = 0;
        else if (ms[m] == 1) ms[m] = 2;
        else begin
          int md, eq, bad;
          md = mpr[m] ? 1 : mpj[m] * 2 + mpk[m];
          case (md)
            0: eq = mpq[m];
            1: eq = 0;
            2: eq = 1;
            default: eq = 1 - mpq[m];
          endcase
          bad = (int'(q) != eq) || (qn == q);
          mmode[m][md] = (mmode[m][md] < cmax[m]) ? mmode[m][md] + 1 : cmax[m];
          if (bad) begin
            merr[m] = 1;
            if (!mstk[m]) mfem[m] = md;
            mstk[m] = 1;
            mcnt[m] = (mcnt[m] < cmax[m]) ? mcnt[m] + 1 : cmax[m];
            if (stop_cfg[m] != 0) ms[m] = 3;
          end
        end
        mpj[m] = j; mpk[m] = k; mpq[m] = q; mpr[m] = dut_reset;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_err", err_a, merr[0]); chk("a_sticky", stk_a, mstk[0]); chk("a_cnt", cnt_a, mcnt[0]);
    chk("a_fem", fem_a, mfem[0]); chk("a_state", st_a, ms[0]);
    chk("h_err", err_h, merr[1]); chk("h_sticky", stk_h, mstk[1]); chk("h_cnt", cnt_h, mcnt[1]);
    chk("h_fem", fem_h, mfem[1]); chk("h_state", st_h, ms[1]);
    chk("n_err", err_n, merr[2]); chk("n_sticky", stk_n, mstk[2]); chk("n_cnt", cnt_n, mcnt[2]);
    chk("n_fem", fem_n, mfem[2]); chk("n_state", st_n, ms[2]);
`ifdef JK_MON_MODE_COUNTERS_EN
    chk("a_cnt_hold", ch_a, mmode[0][0]); chk("a_cnt_rst", cr_a, mmode[0][1]);
    chk("a_cnt_set", cs_a, mmode[0][2]);  chk("a_cnt_tog", ct_a, mmode[0][3]);
    chk("n_cnt_tog", ct_n, mmode[2][3]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic en, dr, j, k, q, qn;
    int   st, er, sk, cnt, fem;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic r, input logic jj, input logic kk,
                              input logic qq, input logic nn, input int st, input int er,
                              input int sk, input int cn, input int fm);
    vec_t v;
    v.en = e; v.dr = r; v.j = jj; v.k = kk; v.q = qq; v.qn = nn;
    v.st = st; v.er = er; v.sk = sk; v.cnt = cn; v.fem = fm;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic lq, lj, lk, lr, nq;
    for (int m = 0; m < 3; m++) begin
      ms[m] = 0; merr[m] = 0; mstk[m] = 0; mcnt[m] = 0; mfem[m] = 0;
      mpj[m] = 0; mpk[m] = 0; mpq[m] = 0; mpr[m] = 0;
      for (int c = 0; c < 4; c++) mmode[m][c] = 0;
    end

    // en, dut_reset, J, K, Q, Qn  ->  state, err, sticky, err_cnt, first_err_mode (instance a)
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0, 2,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,1,0, 2,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,1,0, 2,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,1, 2,1,1,1,2));
    tbl.push_back(mk(1,0,1,0,0,1, 2,1,1,2,2));
    tbl.push_back(mk(1,0,0,0,1,0, 2,0,1,2,2));
    tbl.push_back(mk(1,0,0,0,1,1, 2,1,1,3,2));
    tbl.push_back(mk(1,0,0,0,1,0, 2,0,1,3,2));
    tbl.push_back(mk(1,0,1,0,0,1, 2,1,1,4,2));
    tbl.push_back(mk(1,0,1,0,0,1, 2,1,1,5,2));
    tbl.push_back(mk(1,0,1,0,0,1, 2,1,1,6,2));
    tbl.push_back(mk(1,1,1,1,0,1, 2,1,1,7,2));
    tbl.push_back(mk(1,0,0,0,0,1, 2,0,1,7,2));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,7,2));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,7,2));

    reset = 1'b0; en = 1'b1; dut_reset = 1'b0; j = 1'b0; k = 1'b0; q = 1'b0; qn = 1'b1;
    tick();
    tick();
    chk("reset_state", st_a, 0); chk("reset_err_cnt", cnt_a, 0); chk("reset_sticky", stk_a, 0);
    reset = 1'b1; en = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; dut_reset = tbl[i].dr; j = tbl[i].j; k = tbl[i].k; q = tbl[i].q; qn = tbl[i].qn;
      tick();
      chk($sformatf("tbl%0d_state", i), st_a, tbl[i].st);
      chk($sformatf("tbl%0d_err", i), err_a, tbl[i].er);
      chk($sformatf("tbl%0d_sticky", i), stk_a, tbl[i].sk);
      chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].cnt);
      chk($sformatf("tbl%0d_fem", i), fem_a, tbl[i].fem);
      if (i == 16) begin
        chk("halt_state", st_h, 3); chk("halt_cnt_held", cnt_h, 1); chk("narrow_cnt_sat", cnt_n, 3);
      end
    end
    chk("halt_left_on_en_low", st_h, 0);

    // en falls on the same edge as a mismatch: no error recorded
    en = 1'b1; j = 1'b1; k = 1'b0; q = 1'b0; qn = 1'b1;
    tick(); tick();
    en = 1'b0;
    tick();
    chk("enfall_err", err_a, 0); chk("enfall_cnt", cnt_a, 0); chk("enfall_state", st_a, 0);

    // reset in the middle of CHECK with two errors counted
    tick();
    en = 1'b1;
    tick(); tick(); tick(); tick();
    chk("pre_reset_cnt", cnt_a, 2);
    reset = 1'b0;
    tick();
    chk("midrst_state", st_a, 0); chk("midrst_err", err_a, 0); chk("midrst_sticky", stk_a, 0);
    chk("midrst_cnt", cnt_a, 0); chk("midrst_fem", fem_a, 0);
    reset = 1'b1; en = 1'b0;
    tick();

    // four correctly-behaving toggles
    en = 1'b1; j = 1'b1; k = 1'b1; q = 1'b0; qn = 1'b1;
    tick(); tick();
    for (int t = 0; t < 4; t++) begin
      q = ~q; qn = ~q;
      tick();
    end
    chk("tog_no_err", stk_a, 0);
`ifdef JK_MON_MODE_COUNTERS_EN
    chk("cnt_tog_4", ct_a, 4);
`endif

    // randomized traffic: mostly well-behaved flop with occasional faults
    lq = q; lj = j; lk = k; lr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 63) != 0);
      en        = ($urandom_range(0, 15) != 0);
      dut_reset = ($urandom_range(0, 9) == 0);
      j         = 1'($urandom_range(0, 1));
      k         = 1'($urandom_range(0, 1));
      nq = lr ? 1'b0 : (lj & ~lk) | (lj & lk & ~lq) | (~lj & ~lk & lq);
      if ($urandom_range(0, 7) == 0) nq = ~nq;
      q  = nq;
      qn = ($urandom_range(0, 15) == 0) ? nq : ~nq;
      lq = q; lj = j; lk = k; lr = dut_reset;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_ff_monitor.md
JK_FF_MONITOR -- requirements
Module: jk_ff_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of every counter output.
REQ-002 Parameter STOP_ON_ERR, default 0: 1 = halt checking after the first error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 en  input  1  monitor enable; low forces IDLE.
REQ-006 dut_reset  input  1  observed JK flop reset, active-high.
REQ-007 J  input  1  observed J.
REQ-008 K  input  1  observed K.
REQ-009 Q  input  1  observed Q.
REQ-010 Qn  input  1  observed Qn.
REQ-011 err  output  1  one-cycle error pulse.
REQ-012 err_sticky  output  1  set by the first error, cleared only by reset or IDLE.
REQ-013 err_cnt  output  CNT_W  saturating error count.
REQ-014 first_err_mode  output  2  mode (0 hold, 1 reset, 2 set, 3 toggle) of the first failing transition.
REQ-015 state  output  2  FSM state (0 IDLE, 1 SYNC, 2 CHECK, 3 HALT).

Function
REQ-016 The FSM SHALL go IDLE->SYNC when en=1, SYNC->CHECK on the next cycle, and any state->IDLE when en=0.
REQ-017 In SYNC and CHECK, each edge SHALL register J, K, Q and dut_reset as prev_* and set prev_valid=1; IDLE SHALL clear prev_valid.
REQ-018 In CHECK with prev_valid=1 and prev_dut_reset=0, expected Q SHALL be: hold (prev_q) for 00, 0 for 01, 1 for 10, ~prev_q for 11.
REQ-019 In CHECK with prev_dut_reset=1, expected Q SHALL be 0, regardless of J/K.
REQ-020 An error SHALL be detected in CHECK when Q != expected Q, or Qn != ~Q.
REQ-021 err SHALL be registered, asserted the cycle after the edge where the mismatch is sampled, and last exactly one cycle per failing sample.
REQ-022 Each error SHALL increment err_cnt by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-023 On the first error since entering SYNC, first_err_mode SHALL capture the prev J/K mode, with reset reported as mode 1; later errors SHALL not change it.
REQ-024 Checking SHALL compare against observed prev_q rather than a free-running model, so a single DUT fault yields exactly one error.
REQ-025 When STOP_ON_ERR=1, CHECK SHALL move to HALT on an error; HALT performs no checks, holds all outputs except err (0) and leaves only when en=0.
REQ-026 When en falls in the same cycle as a mismatch, the move to IDLE SHALL take priority and no error is recorded.
REQ-027 Entering SYNC from IDLE SHALL clear err_sticky, err_cnt and first_err_mode.

Reset
REQ-028 With reset=0 at an edge: state=IDLE, err=0, err_sticky=0, err_cnt=0, first_err_mode=0, prev_valid=0, all mode counters=0.
REQ-029 reset SHALL override en and any in-progress check, and takes effect at the next rising edge.

Configuration
REQ-030 Macro JK_MON_MODE_COUNTERS_EN, when defined, SHALL add outputs cnt_hold, cnt_set, cnt_rst and cnt_tog (each CNT_W, saturating).
REQ-031 These counters SHALL count each checked transition in CHECK by its prev mode, whether it passes or fails, and are cleared like err_cnt.
REQ-032 Without the macro, the ports and counters SHALL not exist, and all other behaviour SHALL be unchanged.

Structure
REQ-033 Package jk_mon_pkg SHALL hold the state enum (IDLE, SYNC, CHECK, HALT), the mode encoding constants and a function jk_next(j, k, q).
REQ-034 Sub-module jk_expect SHALL be combinational, mapping prev_j, prev_k, prev_q and prev_dut_reset to the expected Q and the mode.

Verification
REQ-035 Correct DUT sequence: en=1, then J/K = 10, 00, 01, 11, 11 -> Q follows 1, 1, 0, 1, 0; err never asserts; err_cnt=0.
REQ-036 Faulty DUT with Q stuck at 0, J/K=10 in CHECK -> err pulses once per sample; err_cnt=1, 2, ...; first_err_mode=2; err_sticky=1.
REQ-037 Qn forced equal to Q for one cycle -> exactly one err pulse; err_cnt=1.
REQ-038 STOP_ON_ERR=1 with one induced fault -> state=3 (HALT); err_cnt stays 1 despite further faults; en=0 -> state=0.
REQ-039 CNT_W=2 with 5 faults -> err_cnt saturates at 3; dut_reset=1 with Q=0 -> no error.
REQ-040 reset=0 asserted mid-CHECK with err_cnt=2 -> next cycle state=0 and all outputs 0; with the macro defined, 4 checked toggles -> cnt_tog=4.
